// File: rtl/layer1_activate_drain_if.sv
// Column-in / lane-out handshake bundle for the layer-1 activate-and-drain stage.
// The master side is the upstream MAC array plus downstream consumer; the slave side is the stage itself.
interface layer1_activate_drain_if #(
  parameter int LANES = 10,
  parameter int W     = 16
);
  logic [LANES*W-1:0] column;
  logic               col_valid;
  logic               col_ready;
  logic               bias_wr_en;
  logic [3:0]         bias_wr_addr;
  logic [W-1:0]       bias_wr_data;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic [3:0]         out_idx;
  logic               out_last;

  modport master (
    output column, col_valid, bias_wr_en, bias_wr_addr, bias_wr_data, out_ready,
    input  col_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  column, col_valid, bias_wr_en, bias_wr_addr, bias_wr_data, out_ready,
    output col_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/layer1_activate_drain.sv
// Captures a MAC column, adds per-lane bias with signed saturation, then drains one lane per handshake.
// Define L1_RELU_EN to clamp negative results to zero; otherwise the activation is linear.
module layer1_activate_drain #(
  parameter int LANES = 10,
  parameter int W     = 16
) (
  input logic clk,
  input logic reset,
  layer1_activate_drain_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'(LANES - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t       state_q;
  logic [3:0]   ptr_q;
  logic         col_ready_q;
  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic [W-1:0] bias_q [LANES];
  logic [W-1:0] res_q  [LANES];
  logic [W-1:0] act_d  [LANES];
  logic [W:0]   sum_w  [LANES];
  logic [W-1:0] sat_w  [LANES];
  logic [W-1:0] next_data;

  // One extra bit of headroom makes overflow visible as a mismatch of the top two sum bits.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_w[i] = {bus.column[i*W+W-1], bus.column[i*W +: W]} + {bias_q[i][W-1], bias_q[i]};
      if (sum_w[i][W] != sum_w[i][W-1])
        sat_w[i] = sum_w[i][W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
        sat_w[i] = sum_w[i][W-1:0];
`ifdef L1_RELU_EN
      act_d[i] = sat_w[i][W-1] ? '0 : sat_w[i];
`else
      act_d[i] = sat_w[i];
`endif
    end
  end

  always_comb begin
    next_data = '0;
    for (int i = 0; i < LANES; i++)
      if (ptr_q + 4'd1 == 4'(i))
        next_data = res_q[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++)
        bias_q[i] <= '0;
    end else if (bus.bias_wr_en) begin
      for (int i = 0; i < LANES; i++)
        if (bus.bias_wr_addr == 4'(i))
          bias_q[i] <= bus.bias_wr_data;
    end
  end

  // out_data is preloaded one lane ahead so it stays a pure register output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      col_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < LANES; i++)
        res_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.col_valid) begin
            for (int i = 0; i < LANES; i++)
              res_q[i] <= act_d[i];
            out_data_q  <= act_d[0];
            ptr_q       <= '0;
            col_ready_q <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (ptr_q == LAST_IDX) begin
              ptr_q       <= '0;
              col_ready_q <= 1'b1;
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              ptr_q      <= ptr_q + 4'd1;
              out_data_q <= next_data;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.col_ready = col_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = ptr_q;
  assign bus.out_last  = out_valid_q && (ptr_q == LAST_IDX);

endmodule

// File: tb/tb_layer1_activate_drain.sv
// Directed, table-driven bench for layer1_activate_drain plus hand-written backpressure,
// same-cycle bias write and mid-drain reset sequences.
module tb_layer1_activate_drain;

  localparam int LANES = 10;
  localparam int W     = 16;
`ifdef L1_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct packed {
    logic [LANES*W-1:0] col;
    logic [LANES*W-1:0] bias;
    logic [LANES*W-1:0] expv;
  } vec_t;

  logic clock;
  logic reset;
  int   assertCount;
  int   failCount;
  vec_t vecs [3];

  layer1_activate_drain_if #(.LANES(LANES), .W(W)) bus ();

  layer1_activate_drain #(.LANES(LANES), .W(W)) dut (
    .clk   (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic writeBiases(input logic [LANES*W-1:0] b);
    for (int i = 0; i < LANES; i++) begin
      @(negedge clock);
      bus.bias_wr_en   = 1'b1;
      bus.bias_wr_addr = 4'(i);
      bus.bias_wr_data = b[i*W +: W];
    end
    @(negedge clock);
    bus.bias_wr_en = 1'b0;
  endtask

  // Presents a column for one cycle; returns at the negedge right after the capture edge.
  task automatic applyStimulus(input logic [LANES*W-1:0] col);
    @(negedge clock);
    bus.column    = col;
    bus.col_valid = 1'b1;
    @(negedge clock);
    bus.col_valid = 1'b0;
  endtask

  task automatic drainAndCheck(input logic [LANES*W-1:0] expv, input bit randomReady, input bit disturb);
    int lane;
    int cycles;
    lane   = 0;
    cycles = 0;
    while (lane < LANES && cycles < 400) begin
      bus.out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (disturb) begin
        bus.column       = {$urandom, $urandom, $urandom, $urandom, $urandom};
        bus.col_valid    = 1'($urandom_range(0, 1));
        bus.bias_wr_en   = 1'b1;
        bus.bias_wr_addr = 4'($urandom_range(0, 15));
        bus.bias_wr_data = 16'($urandom);
      end
      checkOutput($sformatf("drain_valid_l%0d", lane), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("drain_ready_l%0d", lane), 32'(bus.col_ready), 32'd0);
      checkOutput($sformatf("drain_idx_l%0d", lane), 32'(bus.out_idx), 32'(lane));
      checkOutput($sformatf("drain_data_l%0d", lane), 32'(bus.out_data), 32'(expv[lane*W +: W]));
      checkOutput($sformatf("drain_last_l%0d", lane), 32'(bus.out_last), 32'(lane == LANES - 1));
      if (bus.out_ready) lane++;
      cycles++;
      @(negedge clock);
    end
    if (lane < LANES)
      checkOutput("drain_timeout_lanes", 32'(lane), 32'(LANES));
    bus.col_valid  = 1'b0;
    bus.bias_wr_en = 1'b0;
    bus.out_ready  = 1'b1;
    checkOutput("post_drain_col_ready", 32'(bus.col_ready), 32'd1);
    checkOutput("post_drain_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("post_drain_out_last", 32'(bus.out_last), 32'd0);
    @(negedge clock);
    checkOutput("no_second_capture", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [LANES*W-1:0] c, b, e;
    assertCount = 0;
    failCount   = 0;

    // Vector 0: all 0x0005, zero bias.
    for (int i = 0; i < LANES; i++) begin
      c[i*W +: W] = 16'h0005; b[i*W +: W] = 16'h0000; e[i*W +: W] = 16'h0005;
    end
    vecs[0] = '{col: c, bias: b, expv: e};
    // Vector 1: 0x0100 plus bias i.
    for (int i = 0; i < LANES; i++) begin
      c[i*W +: W] = 16'h0100; b[i*W +: W] = 16'(i); e[i*W +: W] = 16'h0100 + 16'(i);
    end
    vecs[1] = '{col: c, bias: b, expv: e};
    // Vector 2: saturation and sign corners.
    c[0*W +: W] = 16'h7FF0; b[0*W +: W] = 16'h0020; e[0*W +: W] = 16'h7FFF;
    c[1*W +: W] = 16'h8010; b[1*W +: W] = 16'hFFE0; e[1*W +: W] = RELU ? 16'h0000 : 16'h8000;
    c[2*W +: W] = 16'hFFFE; b[2*W +: W] = 16'h0000; e[2*W +: W] = RELU ? 16'h0000 : 16'hFFFE;
    c[3*W +: W] = 16'h1234; b[3*W +: W] = 16'h0010; e[3*W +: W] = 16'h1244;
    c[4*W +: W] = 16'h7FFF; b[4*W +: W] = 16'h7FFF; e[4*W +: W] = 16'h7FFF;
    c[5*W +: W] = 16'h8000; b[5*W +: W] = 16'h8000; e[5*W +: W] = RELU ? 16'h0000 : 16'h8000;
    c[6*W +: W] = 16'hFFFF; b[6*W +: W] = 16'h0001; e[6*W +: W] = 16'h0000;
    c[7*W +: W] = 16'h0003; b[7*W +: W] = 16'hFFFC; e[7*W +: W] = RELU ? 16'h0000 : 16'hFFFF;
    c[8*W +: W] = 16'h4000; b[8*W +: W] = 16'h3FFF; e[8*W +: W] = 16'h7FFF;
    c[9*W +: W] = 16'h8001; b[9*W +: W] = 16'hFFFF; e[9*W +: W] = RELU ? 16'h0000 : 16'h8000;
    vecs[2] = '{col: c, bias: b, expv: e};

    bus.column       = '0;
    bus.col_valid    = 1'b0;
    bus.bias_wr_en   = 1'b0;
    bus.bias_wr_addr = '0;
    bus.bias_wr_data = '0;
    bus.out_ready    = 1'b1;
    reset            = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_col_ready", 32'(bus.col_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset_out_idx", 32'(bus.out_idx), 32'd0);
    checkOutput("reset_out_last", 32'(bus.out_last), 32'd0);
    reset = 1'b0;

    // Table vectors; out-of-range bias addresses are poked before each to catch aliasing.
    for (int v = 0; v < 3; v++) begin
      $display("[TB] vector %0d", v);
      writeBiases(vecs[v].bias);
      for (int a = LANES; a < 16; a++) begin
        @(negedge clock);
        bus.bias_wr_en   = 1'b1;
        bus.bias_wr_addr = 4'(a);
        bus.bias_wr_data = 16'h1111;
      end
      @(negedge clock);
      bus.bias_wr_en = 1'b0;
      applyStimulus(vecs[v].col);
      drainAndCheck(vecs[v].expv, 1'b0, 1'b0);
    end

    $display("[TB] backpressure and isolation");
    writeBiases(vecs[2].bias);
    applyStimulus(vecs[2].col);
    drainAndCheck(vecs[2].expv, 1'b1, 1'b1);

    $display("[TB] bias write in capture cycle");
    writeBiases('0);
    for (int i = 0; i < LANES; i++) begin
      c[i*W +: W] = 16'h0010; e[i*W +: W] = 16'h0010;
    end
    @(negedge clock);
    bus.column       = c;
    bus.col_valid    = 1'b1;
    bus.bias_wr_en   = 1'b1;
    bus.bias_wr_addr = 4'd0;
    bus.bias_wr_data = 16'h0100;
    @(negedge clock);
    bus.col_valid  = 1'b0;
    bus.bias_wr_en = 1'b0;
    drainAndCheck(e, 1'b0, 1'b0);
    e[0 +: W] = 16'h0110;
    applyStimulus(c);
    drainAndCheck(e, 1'b0, 1'b0);

    $display("[TB] mid-drain reset");
    writeBiases(vecs[1].bias);
    for (int i = 0; i < LANES; i++) c[i*W +: W] = 16'h0200;
    applyStimulus(c);
    bus.out_ready = 1'b1;
    for (int l = 0; l < 4; l++) begin
      checkOutput($sformatf("pre_reset_data_l%0d", l), 32'(bus.out_data), 32'(16'h0200 + 16'(l)));
      @(negedge clock);
    end
    checkOutput("pre_reset_idx", 32'(bus.out_idx), 32'd4);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_reset_col_ready", 32'(bus.col_ready), 32'd1);
    checkOutput("async_reset_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("async_reset_out_idx", 32'(bus.out_idx), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      c[i*W +: W] = 16'h0A00 + 16'(i); e[i*W +: W] = 16'h0A00 + 16'(i);
    end
    applyStimulus(c);
    drainAndCheck(e, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
